// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: sequences one single-port masked RW SRAM macro (RW0_* interface) and
// shares it between two requesters.
//   - After reset, sweeps every entry to zero (one write per cycle, DEPTH cycles).
//   - Then grants at most one access per cycle, round-robin when both requesters are valid.
//   - Read data returns one cycle after acceptance on the shared resp_rdata bus, qualified
//     by the per-requester resp_valid strobe.
// Ports:
//   clock, reset               clock and asynchronous active-high reset
//   req_valid/ready/write      per-requester handshake and direction (bit i = requester i)
//   req_addr/wdata/wmask       packed per-requester address, write data and lane mask
//   resp_valid, resp_rdata     read response strobe per requester, shared data
//   init_done                  high once the zero sweep has completed
//   RW0_*                      SRAM macro interface
module sram_rw_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned MASK_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [2*MASK_W-1:0]   req_wmask,
  output logic [1:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_wmode,
  output logic [MASK_W-1:0]     RW0_wmask,
  output logic [DATA_W-1:0]     RW0_wdata,
  input  logic [DATA_W-1:0]     RW0_rdata
);

  typedef enum logic {StInit, StRun} state_e;

  state_e            state_q, state_d;
  // One extra bit so the terminal compare cannot wrap.
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              gnt_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      rr_ptr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    gnt_idx    = 1'b0;
    req_ready  = 2'b00;
    init_done  = 1'b0;
    RW0_en     = 1'b0;
    RW0_wmode  = 1'b0;
    RW0_wmask  = '0;
    RW0_wdata  = '0;
    RW0_addr   = '0;

    unique case (state_q)
      StInit: begin
        RW0_en     = 1'b1;
        RW0_wmode  = 1'b1;
        RW0_wmask  = '1;
        RW0_addr   = init_cnt_q[ADDR_W-1:0];
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        init_done = 1'b1;
        // A lone valid requester wins outright; rr_ptr only breaks ties.
        gnt_idx   = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
        if (|req_valid) begin
          req_ready[gnt_idx] = 1'b1;
          RW0_en     = 1'b1;
          RW0_wmode  = req_write[gnt_idx];
          RW0_addr   = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          RW0_wdata  = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          RW0_wmask  = gnt_idx ? req_wmask[2*MASK_W-1:MASK_W] : req_wmask[MASK_W-1:0];
          rd_pend_d  = ~req_write[gnt_idx];
          rd_owner_d = gnt_idx;
          rr_ptr_d   = ~gnt_idx;
        end
      end
      default: state_d = StInit;
    endcase

    // Keep the macro idle while reset is held, even though state already reads as INIT.
    if (reset) begin
      req_ready = 2'b00;
      init_done = 1'b0;
      RW0_en    = 1'b0;
      RW0_wmode = 1'b0;
      RW0_wmask = '0;
      RW0_wdata = '0;
      RW0_addr  = '0;
    end
  end

  assign resp_valid = {rd_pend_q & rd_owner_q, rd_pend_q & ~rd_owner_q};
  assign resp_rdata = RW0_rdata;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: behavioural SRAM macro, array-level reference model and a
// response scoreboard checked by an independent monitor.
module tb_sram_rw_arbiter;
  localparam int AW = 9;
  localparam int DW = 128;
  localparam int MW = 4;
  localparam int DEPTH = 512;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [2*MW-1:0] req_wmask = '0;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            init_done;
  logic [AW-1:0]   RW0_addr;
  logic            RW0_en;
  logic            RW0_wmode;
  logic [MW-1:0]   RW0_wmask;
  logic [DW-1:0]   RW0_wdata;
  logic [DW-1:0]   RW0_rdata;

  sram_rw_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .MASK_W(MW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural macro: masked write, registered read.
  logic [DW-1:0] mac_mem [DEPTH];
  logic [DW-1:0] mac_rdata;
  assign RW0_rdata = mac_rdata;
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int l = 0; l < MW; l++)
          if (RW0_wmask[l]) mac_mem[RW0_addr][l*32 +: 32] <= RW0_wdata[l*32 +: 32];
      end else begin
        mac_rdata <= mac_mem[RW0_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: array contents, tie-break pointer, expected responses.
  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_rr;

  task automatic model_clear();
    sb.delete();
    m_rr = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Monitor: every response must match the oldest expectation, in its due cycle.
  exp_t mon_e;
  always @(negedge clock) begin
    if (resp_valid != 2'b00) begin
      chk(sb.size() != 0, "unexpected_resp", resp_valid, 0);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk(mon_e.due == cyc, "resp_cycle", cyc, mon_e.due);
        chk(resp_valid == (mon_e.owner ? 2'b10 : 2'b01), "resp_owner", resp_valid,
            mon_e.owner ? 2'b10 : 2'b01);
        chk(resp_rdata == mon_e.data, "resp_data", resp_rdata, mon_e.data);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk(1'b0, "missing_resp", 0, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid = '0;
    model_clear();
    repeat (cycles - 1) @(posedge clock);
    @(negedge clock);
    chk(!RW0_en && req_ready == 0 && resp_valid == 0 && !init_done && RW0_addr == 0,
        "reset_outputs", {RW0_en, req_ready, resp_valid, init_done}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Observe the sweep from the first post-reset cycle; returns at negedge of first RUN cycle.
  task automatic wait_init();
    int n = 0;
    int bad = 0;
    while (n < DEPTH + 100) begin
      @(negedge clock);
      if (init_done) break;
      if (!(RW0_en && RW0_wmode && RW0_wmask == 4'hF && RW0_wdata == 0 &&
            RW0_addr == n[AW-1:0] && req_ready == 0)) bad++;
      n++;
    end
    chk(n == DEPTH, "init_cycles", n, DEPTH);
    chk(bad == 0, "init_sweep_pattern", bad, 0);
  endtask

  // One cycle of stimulus; grant and macro drive are checked against the model.
  task automatic cycle(input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [MW-1:0] m0, input logic [MW-1:0] m1);
    logic [1:0]    g;
    logic          i;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    @(posedge clock);
    #1;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    req_wmask = {m1, m0};
    @(negedge clock);
    if (v == 2'b11) g = m_rr ? 2'b10 : 2'b01;
    else g = v;
    chk(req_ready == g, "grant", req_ready, g);
    if (g != 2'b00) begin
      i = g[1];
      a = i ? a1 : a0;
      d = i ? d1 : d0;
      m = i ? m1 : m0;
      chk(RW0_en && RW0_addr == a && RW0_wmode == w[i], "macro_cmd",
          {RW0_en, RW0_wmode, RW0_addr}, {1'b1, w[i], a});
      if (w[i]) begin
        chk(RW0_wdata == d && RW0_wmask == m, "macro_wr", {RW0_wmask, RW0_wdata}, {m, d});
        for (int l = 0; l < MW; l++)
          if (m[l]) ref_mem[a][l*32 +: 32] = d[l*32 +: 32];
      end else begin
        sb.push_back('{owner: i, data: ref_mem[a], due: cyc + 1});
      end
      m_rr = (i == 1'b0);
    end else begin
      chk(!RW0_en, "macro_idle", RW0_en, 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic rd(input logic i, input logic [AW-1:0] a);
    if (i) cycle(2'b10, 2'b00, '0, a, '0, '0, '0, '0);
    else   cycle(2'b01, 2'b00, a, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] pat;
    pat = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    model_clear();

    // Reset then idle sweep; top entry must read back zero.
    do_reset(3);
    wait_init();
    rd(1'b0, 9'h1FF);
    idle(2);

    // Masked write followed immediately by readback.
    cycle(2'b01, 2'b01, 9'h005, '0, pat, '0, 4'b0101, '0);
    rd(1'b0, 9'h005);
    idle(2);

    // Put rr_ptr back to 0, then contend for six cycles.
    rd(1'b1, 9'h005);
    for (int k = 0; k < 6; k++)
      cycle(2'b11, 2'b00, AW'(k), AW'(9'h005), '0, '0, '0, '0);
    idle(2);

    // Requester 1 streaming after writing distinct values to 0..7.
    for (int k = 0; k < 8; k++)
      cycle(2'b01, 2'b01, AW'(k), '0, {4{32'(k * 32'h01010101 + 7)}}, '0, 4'hF, '0);
    for (int k = 0; k < 8; k++) rd(1'b1, AW'(k));
    idle(2);

    // Random traffic on a small address window to force collisions.
    for (int k = 0; k < 400; k++)
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            4'($urandom), 4'($urandom));
    idle(3);
    chk(sb.size() == 0, "drain_random", sb.size(), 0);

    // Reset mid-INIT: the sweep restarts from zero and runs its full length.
    do_reset(3);
    repeat (200) @(posedge clock);
    do_reset(2);
    wait_init();
    for (int k = 0; k < 16; k++) rd(k[0], AW'(k));
    idle(2);

    // Reset with a read pending: the response must never appear.
    cycle(2'b01, 2'b01, 9'h003, '0, pat, '0, 4'hF, '0);
    rd(1'b0, 9'h003);
    do_reset(2);
    wait_init();
    idle(4);
    chk(sb.size() == 0, "drain_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
